// File: rtl/dmem_if.sv
// Request/response bundle between one data-memory requester and the arbiter.
// The master drives the request fields and the arbiter (slave) drives the grant and response.
interface dmem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, we, funct3, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: one registered access every three cycles,
// with illegal accesses rejected before they reach memory and master 1 protected from starvation.
//
// state  | meaning
// IDLE   | waiting for a request; the winner is granted combinationally
// ACCESS | registered request drives the memory; the read data is captured at the edge
// RESP   | one-cycle rvalid pulse to the master that was granted
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 64,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_if.slave                 m0,
    dmem_if.slave                 m1,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]         WAIT_LIMIT = WW'(MAX_WAIT);
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH + 1)'(MEM_SIZE * 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  reg_we;
    logic [2:0]            reg_funct3;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  reg_id;
    logic                  reg_err;
    logic [WW-1:0]         wait_cnt;

    logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
    logic                  m0_err_q, m1_err_q;

    logic                  any_req;
    logic                  win1;
    logic                  sel_we;
    logic [2:0]            sel_funct3;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] rdata_cap;

    logic gnt0, gnt1, rvalid0, rvalid1, wr_en, busy_c;

    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [ADDR_WIDTH-1:0] addr);
        logic e;
        e = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: e = 1'b0;
            3'b100, 3'b101:         e = we;
            default:                e = 1'b1;
        endcase
        if ((f3 == 3'b001 || f3 == 3'b101) && addr[0])
            e = 1'b1;
        if (f3 == 3'b010 && addr[1:0] != 2'b00)
            e = 1'b1;
        if ({1'b0, addr} >= MEM_BYTES)
            e = 1'b1;
        return e;
    endfunction

    // m0 has fixed priority until master 1 has lost MAX_WAIT arbitrations in a row
    assign any_req = m0.req | m1.req;
    assign win1    = m1.req & (~m0.req | (wait_cnt == WAIT_LIMIT));

    assign sel_we     = win1 ? m1.we     : m0.we;
    assign sel_funct3 = win1 ? m1.funct3 : m0.funct3;
    assign sel_addr   = win1 ? m1.addr   : m0.addr;
    assign sel_wdata  = win1 ? m1.wdata  : m0.wdata;
    assign sel_err    = access_err(sel_we, sel_funct3, sel_addr);

    assign rdata_cap  = (reg_we | reg_err) ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rst_n gates the grants directly because the state register is already IDLE during reset
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        wr_en   = 1'b0;
        busy_c  = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                gnt0   = rst_n & m0.req & ~win1;
                gnt1   = rst_n & win1;
            end
            ACCESS: wr_en = reg_we & ~reg_err;
            RESP: begin
                rvalid0 = ~reg_id;
                rvalid1 = reg_id;
            end
            default: busy_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we     <= 1'b0;
            reg_funct3 <= 3'b000;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_id     <= 1'b0;
            reg_err    <= 1'b0;
            wait_cnt   <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                reg_we     <= sel_we;
                reg_funct3 <= sel_funct3;
                reg_addr   <= sel_addr;
                reg_wdata  <= sel_wdata;
                reg_id     <= win1;
                reg_err    <= sel_err;
                if (win1)
                    wait_cnt <= '0;
                else if (m1.req && wait_cnt != WAIT_LIMIT)
                    wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == ACCESS) begin
                if (reg_id) begin
                    m1_rdata_q <= rdata_cap;
                    m1_err_q   <= reg_err;
                end else begin
                    m0_rdata_q <= rdata_cap;
                    m0_err_q   <= reg_err;
                end
            end
        end
    end

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rvalid0;
    assign m1.rvalid = rvalid1;
    assign m0.rdata  = m0_rdata_q;
    assign m1.rdata  = m1_rdata_q;
    assign m0.err    = m0_err_q;
    assign m1.err    = m1_err_q;

    assign mem_wr_en  = wr_en;
    assign mem_funct3 = reg_funct3;
    assign mem_addr   = reg_addr;
    assign mem_wdata  = reg_wdata;
    assign busy       = busy_c;
endmodule
